// File: rtl/lif_neuron_array_if.sv
// Synaptic-event input stream and spike-index output stream of the LIF neuron array.
// The slave side is the neuron array; the master side is the event source / spike sink.
interface lif_neuron_array_if #(
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned WEIGHT_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W-1:0]        in_idx;
  logic [WEIGHT_WIDTH-1:0] in_weight;
  logic                    spike_valid;
  logic                    spike_ready;
  logic [IDX_W-1:0]        spike_idx;

  modport master (
    output in_valid, in_idx, in_weight, spike_ready,
    input  in_ready, spike_valid, spike_idx
  );

  modport slave (
    input  in_valid, in_idx, in_weight, spike_ready,
    output in_ready, spike_valid, spike_idx
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: integrates events while idle,
// then sweeps every neuron once per tick (leak, threshold, refractory) emitting spike indices.
module lif_neuron_array #(
  parameter int unsigned NUM_NEURONS    = 16,
  parameter int unsigned MEMBRANE_WIDTH = 32,
  parameter int unsigned WEIGHT_WIDTH   = 32,
  parameter int unsigned LEAK_WIDTH     = 8,
  parameter logic [MEMBRANE_WIDTH-1:0] THRESHOLD = 32'h0000_8000,
  parameter logic [MEMBRANE_WIDTH-1:0] RESET_VAL = 32'h0000_0000,
  parameter int unsigned REFRACT_STEPS  = 2,
  parameter int unsigned LEAK_MODE      = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lif_neuron_array_if.slave     bus,
  input  logic                  tick_i,
  input  logic [LEAK_WIDTH-1:0] leak_i,
  output logic                  step_done_o,
  output logic                  busy_o,
  output logic                  tick_miss_o
);
  localparam int unsigned IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned REFR_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
  localparam int unsigned MW     = MEMBRANE_WIDTH;

  typedef logic signed [MW-1:0] mem_t;

  localparam mem_t MemMax = {1'b0, {(MW-1){1'b1}}};
  localparam mem_t MemMin = {1'b1, {(MW-1){1'b0}}};

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0] spike_idx_q, spike_idx_d;
  logic             tick_miss_q, tick_miss_d;

  mem_t             mem_q  [NUM_NEURONS];
  logic [REFR_W-1:0] refr_q [NUM_NEURONS];

  // Event integration with saturation
  mem_t        ev_mem, w_ext, ev_sat;
  logic [MW:0] ev_sum;
  logic        ev_accept;

  always_comb begin
    ev_mem    = mem_q[bus.in_idx];
    w_ext     = mem_t'($signed(bus.in_weight));
    ev_sum    = {ev_mem[MW-1], ev_mem} + {w_ext[MW-1], w_ext};
    ev_sat    = (ev_sum[MW] != ev_sum[MW-1]) ? (ev_sum[MW] ? MemMin : MemMax) : ev_sum[MW-1:0];
    ev_accept = (state_q == StIdle) && bus.in_valid && (refr_q[bus.in_idx] == '0);
  end

  // Sweep datapath for the neuron at idx_q
  mem_t              cur_mem, leak_ext, leaked;
  logic [REFR_W-1:0] cur_refr;
  logic              fire, advance, sweep_upd;

  always_comb begin
    cur_mem  = mem_q[idx_q];
    cur_refr = refr_q[idx_q];
    leak_ext = mem_t'({1'b0, leak_i});
    if (LEAK_MODE == 0) begin
      leaked = (leak_i == '0) ? cur_mem : cur_mem - (cur_mem >>> leak_i);
    end else if (cur_mem > leak_ext) begin
      leaked = cur_mem - leak_ext;
    end else if (cur_mem < -leak_ext) begin
      leaked = cur_mem + leak_ext;
    end else begin
      leaked = '0;
    end
    fire      = (cur_refr == '0) && (leaked >= mem_t'(THRESHOLD));
    // A pending spike not yet taken freezes the sweep
    advance   = !(spike_valid_q && !bus.spike_ready);
    sweep_upd = (state_q == StSweep) && advance;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spike_valid_d = spike_valid_q;
    spike_idx_d   = spike_idx_q;
    tick_miss_d   = tick_miss_q | (tick_i && (state_q != StIdle));
    if (spike_valid_q && bus.spike_ready) begin
      spike_valid_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (tick_i) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (advance) begin
          spike_valid_d = fire;
          if (fire) begin
            spike_idx_d = idx_q;
          end
          if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
            state_d = StFlush;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StFlush: begin
        if (advance) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      tick_miss_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
      tick_miss_q   <= tick_miss_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        mem_q[i]  <= RESET_VAL;
        refr_q[i] <= '0;
      end
    end else if (ev_accept) begin
      mem_q[bus.in_idx] <= ev_sat;
    end else if (sweep_upd) begin
      if (cur_refr != '0) begin
        refr_q[idx_q] <= cur_refr - REFR_W'(1);
      end else if (fire) begin
        mem_q[idx_q]  <= RESET_VAL;
        refr_q[idx_q] <= REFR_W'(REFRACT_STEPS);
      end else begin
        mem_q[idx_q]  <= leaked;
      end
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_idx   = spike_idx_q;
  assign step_done_o     = (state_q == StFlush) && advance;
  assign busy_o          = (state_q != StIdle);
  assign tick_miss_o     = tick_miss_q;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: a multiplicative-leak and a subtractive-leak instance share stimulus
// and are compared every cycle against a per-timestep arithmetic model of the neuron array.
module tb_lif_neuron_array;
  localparam int    N   = 4;
  localparam longint THR = 64'h8000;
  localparam int    RS  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [7:0]  leak = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_idx = '0;
  logic [31:0] in_weight = '0;
  logic        spike_ready = 1'b1;
  logic        done0, busy0, miss0, done1, busy1, miss1;

  always #5 clk = ~clk;

  lif_neuron_array_if #(.IDX_W(2), .WEIGHT_WIDTH(32)) bus0 ();
  lif_neuron_array_if #(.IDX_W(2), .WEIGHT_WIDTH(32)) bus1 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.in_idx = in_idx;      assign bus1.in_idx = in_idx;
  assign bus0.in_weight = in_weight; assign bus1.in_weight = in_weight;
  assign bus0.spike_ready = spike_ready; assign bus1.spike_ready = spike_ready;

  lif_neuron_array #(.NUM_NEURONS(N), .LEAK_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .tick_i(tick), .leak_i(leak),
    .step_done_o(done0), .busy_o(busy0), .tick_miss_o(miss0)
  );
  lif_neuron_array #(.NUM_NEURONS(N), .LEAK_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .tick_i(tick), .leak_i(leak),
    .step_done_o(done1), .busy_o(busy1), .tick_miss_o(miss1)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int tick_cyc = 0;
  bit chk_en = 0;

  // Model: index 0 = shift leak, index 1 = subtractive leak
  longint mem [2][N];
  int     refr[2][N];
  bit     fire[2][N];
  bit     sw[2];
  int     p[2];
  int     pend[2];
  bit     miss[2];

  int spk0[$];
  int spk1[$];
  int done_cnt[2];
  int done_cyc[2];
  int stall_cnt[2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint leak_of(input int k, input longint m, input int l);
    if (k == 0) begin
      if (l == 0) return m;
      return m - (m >>> ((l > 63) ? 63 : l));
    end
    if (m > 0) return (m > l) ? m - l : 0;
    if (m < 0) return (m < -l) ? m + l : 0;
    return 0;
  endfunction

  // One timestep applied to the whole array at once
  task automatic timestep(input int k);
    longint v;
    for (int i = 0; i < N; i++) begin
      fire[k][i] = 0;
      if (refr[k][i] > 0) begin
        refr[k][i]--;
      end else begin
        v = leak_of(k, mem[k][i], int'(leak));
        if (v >= THR) begin
          fire[k][i] = 1;
          mem[k][i]  = 0;
          refr[k][i] = RS;
        end else begin
          mem[k][i] = v;
        end
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < N; i++) begin mem[k][i] = 0; refr[k][i] = 0; end
        sw[k] = 0; p[k] = 0; pend[k] = -1; miss[k] = 0;
      end else if (!sw[k]) begin
        if (in_valid && refr[k][in_idx] == 0)
          mem[k][in_idx] = sat(mem[k][in_idx] + longint'($signed(in_weight)));
        if (tick) begin
          timestep(k);
          sw[k] = 1; p[k] = 0; pend[k] = -1;
        end
      end else begin
        if (tick) miss[k] = 1;
        if (p[k] == N && (pend[k] < 0 || spike_ready)) begin
          sw[k] = 0; pend[k] = -1;
        end else if (!(pend[k] >= 0 && !spike_ready)) begin
          pend[k] = fire[k][p[k]] ? p[k] : -1;
          p[k]++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic a_busy, a_rdy, a_sv, a_done, a_miss;
        logic [1:0] a_idx;
        a_busy = k ? busy1 : busy0;
        a_rdy  = k ? bus1.in_ready : bus0.in_ready;
        a_sv   = k ? bus1.spike_valid : bus0.spike_valid;
        a_idx  = k ? bus1.spike_idx : bus0.spike_idx;
        a_done = k ? done1 : done0;
        a_miss = k ? miss1 : miss0;
        chk($sformatf("busy%0d", k), a_busy, sw[k]);
        chk($sformatf("in_ready%0d", k), a_rdy, !sw[k]);
        chk($sformatf("spike_valid%0d", k), a_sv, pend[k] >= 0);
        if (pend[k] >= 0) chk($sformatf("spike_idx%0d", k), a_idx, pend[k]);
        chk($sformatf("step_done%0d", k), a_done,
            sw[k] && p[k] == N && (pend[k] < 0 || spike_ready));
        chk($sformatf("tick_miss%0d", k), a_miss, miss[k]);
        if (a_sv && spike_ready) begin
          if (k == 0) spk0.push_back(int'(a_idx)); else spk1.push_back(int'(a_idx));
        end
        if (a_sv && !spike_ready) stall_cnt[k]++;
        if (a_done) begin done_cnt[k]++; done_cyc[k] = cyc; end
      end
    end
  end

  function automatic int code(input int q[$]);
    int c = 0;
    foreach (q[i]) c = c * 10 + q[i] + 1;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sw[0] || sw[1]) && n < 300) begin step(); n++; end
    chk("idle_within_bound", n < 300, 1);
  endtask

  task automatic send(input int idx, input longint w);
    wait_idle();
    in_valid = 1; in_idx = 2'(idx); in_weight = 32'(w);
    step();
    in_valid = 0;
  endtask

  task automatic do_tick();
    wait_idle();
    tick = 1; tick_cyc = cyc;
    step();
    tick = 0;
  endtask

  task automatic clear_obs();
    spk0.delete(); spk1.delete();
    done_cnt = '{0, 0}; stall_cnt = '{0, 0};
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk_en = 1;
    step();
    rst = 0;

    // 1: reset mid-sweep, then an empty timestep
    clear_obs();
    do_tick(); step(); step();
    rst = 1; step(); step(); rst = 0;
    chk("t1_in_ready", bus0.in_ready, 1);
    chk("t1_busy", busy0, 0);
    chk("t1_spike_idx", bus0.spike_idx, 0);
    chk("t1_no_done_aborted", done_cnt[0], 0);
    clear_obs();
    do_tick(); wait_idle();
    chk("t1_latency", done_cyc[0] - tick_cyc, 5);
    chk("t1_spikes", code(spk0), 0);
    chk("t1_done_cnt", done_cnt[0], 1);

    // 2: fire, refractory drop, fire again on the third tick
    do_reset(); leak = 0;
    send(2, 64'h9000); clear_obs(); do_tick(); wait_idle();
    chk("t2_fire0", code(spk0), 3);
    chk("t2_fire1", code(spk1), 3);
    clear_obs(); do_tick(); wait_idle();
    chk("t2_refr_tick", code(spk0), 0);
    send(2, 64'h9000);
    chk("t2_model_dropped", mem[0][2], 0);
    clear_obs(); do_tick(); wait_idle();
    chk("t2_tick3", code(spk0), 0);
    send(2, 64'h9000); clear_obs(); do_tick(); wait_idle();
    chk("t2_refire", code(spk0), 3);

    // 3: leak modes
    do_reset();
    send(0, 64'h4000); leak = 1; clear_obs(); do_tick(); wait_idle();
    chk("t3_model_shift", mem[0][0], 64'h2000);
    chk("t3_model_sub", mem[1][0], 64'h3FFF);
    chk("t3_nospike", code(spk0), 0);
    leak = 0; send(0, 64'h6000); clear_obs(); do_tick(); wait_idle();
    chk("t3_exact_thr", code(spk0), 1);
    do_reset();
    send(0, -64'sd32); leak = 8'h10;
    do_tick(); wait_idle();
    chk("t3_sub_a", mem[1][0], -16);
    chk("t3_shift_a", mem[0][0], -31);
    do_tick(); wait_idle();
    chk("t3_sub_b", mem[1][0], 0);
    do_tick(); wait_idle();
    chk("t3_sub_c", mem[1][0], 0);
    leak = 0; send(0, 64'h8000); clear_obs(); do_tick(); wait_idle();
    chk("t3_sub_zero_fire", code(spk1), 1);
    chk("t3_shift_nofire", code(spk0), 0);

    // 4: saturation
    do_reset();
    send(1, 64'h7FFFFFFF); send(1, 64'h7FFFFFFF);
    send(3, -64'sd2147483648); send(3, -64'sd2147483648); send(3, -64'sd2147483648);
    chk("t4_model_max", mem[0][1], 64'sd2147483647);
    chk("t4_model_min", mem[0][3], -64'sd2147483648);
    send(3, -64'sd2147483648); send(3, 64'h9000);
    clear_obs(); do_tick(); wait_idle();
    chk("t4_spikes", code(spk0), 2);

    // 5: backpressure holds the first spike
    do_reset();
    send(1, 64'h9000); send(3, 64'h9000);
    clear_obs(); spike_ready = 0; do_tick();
    repeat (7) step();
    spike_ready = 1;
    wait_idle();
    chk("t5_spikes", code(spk0), 24);
    chk("t5_stall", stall_cnt[0], 5);
    chk("t5_latency", done_cyc[0] - tick_cyc, 10);
    chk("t5_done_cnt", done_cnt[0], 1);

    // 6: tick while busy, tick together with an event
    do_reset();
    do_tick(); step();
    tick = 1; step(); tick = 0;
    wait_idle();
    chk("t6_miss", miss0, 1);
    repeat (3) step();
    chk("t6_miss_sticky", miss1, 1);
    clear_obs();
    in_valid = 1; in_idx = 0; in_weight = 32'h9000; tick = 1; tick_cyc = cyc;
    step();
    in_valid = 0; tick = 0;
    wait_idle();
    chk("t6_same_cycle", code(spk0), 1);
    do_reset();
    chk("t6_miss_cleared", miss0, 0);

    // Random traffic
    for (int it = 0; it < 1500; it++) begin
      spike_ready = ($urandom_range(0, 3) != 0);
      if (!sw[0] && !sw[1] && $urandom_range(0, 3) == 0)
        leak = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 20));
      in_valid = $urandom_range(0, 1);
      in_idx   = 2'($urandom_range(0, N - 1));
      case ($urandom_range(0, 5))
        0: in_weight = 32'h9000;
        1: in_weight = 32'hFFFF_7000;
        2: in_weight = 32'h7FFF_FFFF;
        3: in_weight = 32'h8000_0000;
        4: in_weight = $urandom;
        default: in_weight = 32'($urandom_range(0, 24576)) - 32'd12288;
      endcase
      tick = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    in_valid = 0; tick = 0; rst = 0; spike_ready = 1;
    wait_idle();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
